// File: rtl/seq_arith_shifter_pkg.sv
// Shared types and encodings for the sequential arithmetic shifter.
// Holds the shift-mode enum, the shifter state enum, and the FSM state constants.
package alu_shift_pkg;

  typedef enum logic [1:0] {
    MODE_ASL = 2'b00,
    MODE_ASR = 2'b01,
    MODE_LSR = 2'b10,
    MODE_ROR = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shifter_state_t;

  // Same encodings as the enum above, in plain-vector form for the FSM register
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/seq_arith_shifter_if.sv
// Start/ready/valid bus between the ALU sequencer (master) and the shifter (slave).
interface seq_arith_shifter_if
  import alu_shift_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [SHAMT_W-1:0] shamt;
  shift_mode_t        mode;
  logic               ready;
  logic               busy;
  logic               valid;
  logic [WIDTH-1:0]   result;
  logic               ovf;

  modport master (
    output start, a, shamt, mode,
    input  ready, busy, valid, result, ovf
  );

  modport slave (
    input  start, a, shamt, mode,
    output ready, busy, valid, result, ovf
  );
endinterface

// File: rtl/seq_arith_shifter_step.sv
// Combinational single-position shift for all four modes.
module shift_step
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  shift_mode_t      i_mode,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_bit_out
);

  // One step; the bit leaving the word is the MSB for left shifts, LSB otherwise
  always_comb begin
    o_data    = i_data;
    o_bit_out = i_data[0];
    case (i_mode)
      MODE_ASL: begin
        o_data    = {i_data[WIDTH-2:0], 1'b0};
        o_bit_out = i_data[WIDTH-1];
      end
      MODE_ASR: o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
      MODE_LSR: o_data = {1'b0, i_data[WIDTH-1:1]};
      MODE_ROR: o_data = {i_data[0], i_data[WIDTH-1:1]};
      default:  o_data = i_data;
    endcase
  end

endmodule

// File: rtl/seq_arith_shifter.sv
// Multi-cycle shifter: one bit position per clock, IDLE -> SHIFT -> DONE handshake.
// Optional ASL overflow flag enabled by defining ASHIFT_OVF_EN; otherwise ovf is tied low.
module seq_arith_shifter
  import alu_shift_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_arith_shifter_if.slave  bus
);

  localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   r_result;
  logic [SHAMT_W-1:0] r_cnt;
  shift_mode_t        r_mode;
  logic [WIDTH-1:0]   w_next;
  logic               w_unused_bit_out;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_mode    (r_mode),
    .i_data    (r_work),
    .o_data    (w_next),
    .o_bit_out (w_unused_bit_out)
  );

  // FSM, work register, counter and the result captured on DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_work   <= {WIDTH{1'b0}};
      r_result <= {WIDTH{1'b0}};
      r_cnt    <= CNT_ZERO;
      r_mode   <= MODE_ASL;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_work <= bus.a;
            r_cnt  <= bus.shamt;
            r_mode <= bus.mode;
            if (bus.shamt == CNT_ZERO) begin
              r_result <= bus.a;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_work <= w_next;
          r_cnt  <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_result <= w_next;
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ASHIFT_OVF_EN
  logic r_orig_msb;
  logic r_ovf_acc;
  logic r_ovf;
  logic w_ovf_step;

  // Sticky overflow: any ASL step whose new MSB differs from the operand's original MSB
  always_comb begin
    w_ovf_step = r_ovf_acc;
    if ((r_mode == MODE_ASL) && (w_next[WIDTH-1] != r_orig_msb)) begin
      w_ovf_step = 1'b1;
    end else begin
      w_ovf_step = r_ovf_acc;
    end
  end

  // Overflow accumulator; the visible flag only moves on DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_orig_msb <= 1'b0;
      r_ovf_acc  <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_orig_msb <= bus.a[WIDTH-1];
            r_ovf_acc  <= 1'b0;
            if (bus.shamt == CNT_ZERO) begin
              r_ovf <= 1'b0;
            end
          end
        end
        S_SHIFT: begin
          r_ovf_acc <= w_ovf_step;
          if (r_cnt == CNT_ONE) begin
            r_ovf <= w_ovf_step;
          end
        end
        default: r_ovf_acc <= r_ovf_acc;
      endcase
    end
  end

  assign bus.ovf = r_ovf;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.ready  = (r_state == S_IDLE);
  assign bus.busy   = (r_state == S_SHIFT);
  assign bus.valid  = (r_state == S_DONE);
  assign bus.result = r_result;

endmodule
